ldst_buffer_controller: RTL



---
 rtl/ldst_buffer_controller.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ldst_buffer_controller.sv
// Circular lw/sw buffer with CDB snooping; issues one in-order memory request at a time.
// Optional LDSTB_LOAD_BYPASS_EN lets the load behind a blocked store issue when addresses differ.
module ldst_buffer_controller #(
    parameter int DEPTH_BITS    = 2,
    parameter int ROB_SIZE_bits = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     AU_LdStB_VALID_Inst,
    input  logic [ROB_SIZE_bits:0]   AU_LdStB_ROBEN,
    input  logic [ROB_SIZE_bits:0]   AU_LdStB_ROBEN1,
    input  logic [ROB_SIZE_bits:0]   AU_LdStB_ROBEN2,
    input  logic [4:0]               AU_LdStB_Rd,
    input  logic [11:0]              AU_LdStB_opcode,
    input  logic [31:0]              AU_LdStB_ROBEN1_VAL,
    input  logic [31:0]              AU_LdStB_ROBEN2_VAL,
    input  logic [31:0]              AU_LdStB_Immediate,
    output logic                     LdStB_FULL,
    input  logic                     CDB_VALID,
    input  logic [ROB_SIZE_bits:0]   CDB_ROBEN,
    input  logic [31:0]              CDB_Write_Data,
    input  logic                     ROB_Commit_VALID,
    input  logic [ROB_SIZE_bits:0]   ROB_Commit_ROBEN,
    output logic                     MEM_REQ,
    output logic                     MEM_WE,
    output logic [31:0]              MEM_ADDR,
    output logic [31:0]              MEM_WDATA,
    input  logic                     MEM_ACK,
    input  logic [31:0]              MEM_RDATA,
    output logic                     LdStB_CDB_VALID,
    output logic [ROB_SIZE_bits:0]   LdStB_CDB_ROBEN,
    output logic [4:0]               LdStB_CDB_Rd,
    output logic [31:0]              LdStB_CDB_DATA,
    output logic                     LdStB_ST_READY_VALID,
    output logic [ROB_SIZE_bits:0]   LdStB_ST_READY_ROBEN
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [11:0] OP_SW = 12'hAC0;

    typedef enum logic {IDLE, WAIT_ACK} state_t;
    typedef logic [DEPTH_BITS-1:0] ptr_t;
    typedef logic [ROB_SIZE_bits:0] tag_t;

    state_t              state;
    ptr_t                head, tail, issue_idx, head_nxt, issue_sel, st_idx;
    logic [DEPTH_BITS:0] count;
    logic [DEPTH-1:0]    e_busy, e_store, e_notified, e_committed;
    tag_t                e_rob [DEPTH];
    tag_t                e_tag1 [DEPTH];
    tag_t                e_tag2 [DEPTH];
    logic [4:0]          e_rd [DEPTH];
    logic [31:0]         e_val1 [DEPTH];
    logic [31:0]         e_val2 [DEPTH];
    logic [31:0]         e_imm [DEPTH];

    logic        full, alloc, alloc_store, free_head, head_elig, do_issue, st_found;
    logic [31:0] head_addr, new_val1, new_val2;
    tag_t        new_tag1, new_tag2;

    assign full        = (count == (DEPTH_BITS+1)'(DEPTH));
    assign LdStB_FULL  = full;
    assign alloc       = AU_LdStB_VALID_Inst && !full;
    assign alloc_store = (AU_LdStB_opcode == OP_SW);
    assign head_nxt    = head + 1'b1;
    assign head_addr   = e_val1[head] + e_imm[head];

`ifdef LDSTB_LOAD_BYPASS_EN
    logic [DEPTH-1:0] e_done;
    logic             byp_ok, skip_done;
    assign head_elig = e_busy[head] && !e_done[head] &&
                       (e_store[head] ? (e_tag1[head] == '0 && e_tag2[head] == '0 && e_committed[head])
                                      : (e_tag1[head] == '0));
    assign byp_ok    = e_busy[head] && e_store[head] && e_tag1[head] == '0 && !head_elig &&
                       e_busy[head_nxt] && !e_store[head_nxt] && !e_done[head_nxt] &&
                       e_tag1[head_nxt] == '0 && (e_val1[head_nxt] + e_imm[head_nxt] != head_addr);
    // A load already serviced out of order just retires when it reaches the head.
    assign skip_done = (state == IDLE) && e_busy[head] && e_done[head];
    assign do_issue  = (state == IDLE) && (head_elig || byp_ok);
    assign issue_sel = head_elig ? head : head_nxt;
    assign free_head = skip_done || (state == WAIT_ACK && MEM_ACK && issue_idx == head);
`else
    assign head_elig = e_busy[head] &&
                       (e_store[head] ? (e_tag1[head] == '0 && e_tag2[head] == '0 && e_committed[head])
                                      : (e_tag1[head] == '0));
    assign do_issue  = (state == IDLE) && head_elig;
    assign issue_sel = head;
    assign free_head = (state == WAIT_ACK) && MEM_ACK;
`endif

    // Scan youngest to oldest so the oldest eligible store is the one left selected.
    always_comb begin
        st_found = 1'b0;
        st_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_busy[head + ptr_t'(i)] && e_store[head + ptr_t'(i)] && !e_notified[head + ptr_t'(i)] &&
                e_tag1[head + ptr_t'(i)] == '0 && e_tag2[head + ptr_t'(i)] == '0) begin
                st_found = 1'b1;
                st_idx   = head + ptr_t'(i);
            end
        end
    end

    always_comb begin
        new_tag1 = AU_LdStB_ROBEN1;
        new_val1 = AU_LdStB_ROBEN1_VAL;
        new_tag2 = alloc_store ? AU_LdStB_ROBEN2 : '0;
        new_val2 = AU_LdStB_ROBEN2_VAL;
        if (CDB_VALID && new_tag1 != '0 && new_tag1 == CDB_ROBEN) begin
            new_tag1 = '0;
            new_val1 = CDB_Write_Data;
        end
        if (CDB_VALID && new_tag2 != '0 && new_tag2 == CDB_ROBEN) begin
            new_tag2 = '0;
            new_val2 = CDB_Write_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state                <= IDLE;
            head                 <= '0;
            tail                 <= '0;
            issue_idx            <= '0;
            count                <= '0;
            e_busy               <= '0;
            e_notified           <= '0;
            e_committed          <= '0;
`ifdef LDSTB_LOAD_BYPASS_EN
            e_done               <= '0;
`endif
            MEM_REQ              <= 1'b0;
            MEM_WE               <= 1'b0;
            MEM_ADDR             <= '0;
            MEM_WDATA            <= '0;
            LdStB_CDB_VALID      <= 1'b0;
            LdStB_CDB_ROBEN      <= '0;
            LdStB_CDB_Rd         <= '0;
            LdStB_CDB_DATA       <= '0;
            LdStB_ST_READY_VALID <= 1'b0;
            LdStB_ST_READY_ROBEN <= '0;
        end else begin
            LdStB_CDB_VALID      <= 1'b0;
            LdStB_ST_READY_VALID <= st_found;
            if (st_found) begin
                LdStB_ST_READY_ROBEN <= e_rob[st_idx];
                e_notified[st_idx]   <= 1'b1;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (e_busy[i]) begin
                    if (CDB_VALID && e_tag1[i] != '0 && e_tag1[i] == CDB_ROBEN) begin
                        e_tag1[i] <= '0;
                        e_val1[i] <= CDB_Write_Data;
                    end
                    if (CDB_VALID && e_tag2[i] != '0 && e_tag2[i] == CDB_ROBEN) begin
                        e_tag2[i] <= '0;
                        e_val2[i] <= CDB_Write_Data;
                    end
                    if (ROB_Commit_VALID && e_store[i] && e_rob[i] == ROB_Commit_ROBEN)
                        e_committed[i] <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (do_issue) begin
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= e_store[issue_sel];
                        MEM_ADDR  <= e_val1[issue_sel] + e_imm[issue_sel];
                        MEM_WDATA <= e_val2[issue_sel];
                        issue_idx <= issue_sel;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        state   <= IDLE;
                        if (!e_store[issue_idx]) begin
                            LdStB_CDB_VALID <= 1'b1;
                            LdStB_CDB_ROBEN <= e_rob[issue_idx];
                            LdStB_CDB_Rd    <= e_rd[issue_idx];
                            LdStB_CDB_DATA  <= MEM_RDATA;
                        end
`ifdef LDSTB_LOAD_BYPASS_EN
                        if (issue_idx != head)
                            e_done[issue_idx] <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (free_head) begin
                e_busy[head] <= 1'b0;
                head         <= head_nxt;
            end

            if (alloc) begin
                e_busy[tail]      <= 1'b1;
                e_store[tail]     <= alloc_store;
                e_notified[tail]  <= 1'b0;
                e_committed[tail] <= 1'b0;
`ifdef LDSTB_LOAD_BYPASS_EN
                e_done[tail]      <= 1'b0;
`endif
                e_rob[tail]       <= AU_LdStB_ROBEN;
                e_rd[tail]        <= AU_LdStB_Rd;
                e_imm[tail]       <= AU_LdStB_Immediate;
                e_tag1[tail]      <= new_tag1;
                e_val1[tail]      <= new_val1;
                e_tag2[tail]      <= new_tag2;
                e_val2[tail]      <= new_val2;
                tail              <= tail + 1'b1;
            end

            count <= count + (DEPTH_BITS+1)'(alloc) - (DEPTH_BITS+1)'(free_head);
        end
    end
endmodule
